// File: rtl/conv_sequencer.sv
// -----------------------------------------------------------------------------
// conv_sequencer
//
// Phase controller for the convolution datapath. It latches the command and
// size registers when a command is accepted, then steps through feature,
// bias and per-channel weight loading, the MAC start/done exchange and output
// draining. It counts beats and drives the status flags read back over APB.
//
// Optional feature: define CONV_SEQ_PERF_EN to build the stall counter on
// perf_stall_cnt. Without it the port is tied to zero and the FSM is unchanged.
//
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   command[2:0]      0=NOP/clear, 1=LOAD_FEAT, 2=LOAD_BIAS, 3=RUN, 4-7 ignored
//   Flen[5:0]         feature map side length
//   num_INCH[8:0]     input channel count
//   num_OUTCH[8:0]    output channel count
//   s_beat            S_AXIS_TVALID & S_AXIS_TREADY
//   m_beat            M_AXIS_TVALID & M_AXIS_TREADY
//   mac_done          one-cycle pulse, current output channel computed
//   s_ready_en        gates S_AXIS_TREADY
//   m_valid_en        gates M_AXIS_TVALID
//   m_last            final output beat of the current channel
//   mac_start         one-cycle pulse in the first MAC cycle
//   outch_idx[8:0]    current output channel
//   beat_idx[19:0]    beat index within the current phase (buffer address)
//   F_writedone, B_writedone, rdy_to_send, conv_done, cmd_err   status flags
//   perf_stall_cnt    stall cycles in SEND/WLOAD (zero unless CONV_SEQ_PERF_EN)
//   state_dbg[2:0]    current FSM state encoding
//
// Handshake: a beat is counted only when the external logic reports a
// completed AXIS transfer (s_beat / m_beat = TVALID & TREADY) while the
// matching enable is high. Enables are registered and depend on state only,
// so there is no combinational path from a beat back to its enable. A beat
// seen outside its enabling state is ignored.
// -----------------------------------------------------------------------------
module conv_sequencer (
    input  logic        CLK,
    input  logic        RST,
    input  logic [2:0]  command,
    input  logic [5:0]  Flen,
    input  logic [8:0]  num_INCH,
    input  logic [8:0]  num_OUTCH,
    input  logic        s_beat,
    input  logic        m_beat,
    input  logic        mac_done,
    output logic        s_ready_en,
    output logic        m_valid_en,
    output logic        m_last,
    output logic        mac_start,
    output logic [8:0]  outch_idx,
    output logic [19:0] beat_idx,
    output logic        F_writedone,
    output logic        B_writedone,
    output logic        rdy_to_send,
    output logic        conv_done,
    output logic        cmd_err,
    output logic [31:0] perf_stall_cnt,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FEAT  = 3'd1,
        BIAS  = 3'd2,
        WLOAD = 3'd3,
        MAC   = 3'd4,
        SEND  = 3'd5,
        HOLD  = 3'd6
    } state_t;

    localparam logic [2:0] CMD_NOP  = 3'd0;
    localparam logic [2:0] CMD_FEAT = 3'd1;
    localparam logic [2:0] CMD_BIAS = 3'd2;
    localparam logic [2:0] CMD_RUN  = 3'd3;

    state_t      state;
    logic [5:0]  flen_q;
    logic [8:0]  inch_q;
    logic [8:0]  outch_q;

    // Ceiling division by 4 without an add that could wrap at 20 bits.
    function automatic logic [19:0] ceil4(input logic [19:0] x);
        return {2'b00, x[19:2]} + {19'd0, |x[1:0]};
    endfunction

    // All size products are truncated to 20 bits before the division.
    function automatic logic [19:0] feat_words(input logic [5:0] f, input logic [8:0] c);
        logic [19:0] sq;
        logic [19:0] prod;
        sq   = 20'(f) * 20'(f);
        prod = sq * 20'(c);
        return ceil4(prod);
    endfunction

    function automatic logic [19:0] out_words(input logic [5:0] f);
        logic [19:0] sq;
        sq = 20'(f) * 20'(f);
        return ceil4(sq);
    endfunction

    logic [19:0] fw_cnt;
    logic [19:0] bw_cnt;
    logic [19:0] ww_cnt;
    logic [19:0] ow_cnt;
    logic [19:0] phase_cnt;
    logic        last_in_beat;
    logic        run_ok;

    assign fw_cnt = feat_words(flen_q, inch_q);
    assign bw_cnt = ceil4(20'(outch_q));
    assign ww_cnt = ceil4(20'(inch_q) * 20'd9);
    assign ow_cnt = out_words(flen_q);

    always_comb begin
        phase_cnt = 20'd0;
        case (state)
            FEAT:    phase_cnt = fw_cnt;
            BIAS:    phase_cnt = bw_cnt;
            WLOAD:   phase_cnt = ww_cnt;
            default: phase_cnt = 20'd0;
        endcase
    end

    assign last_in_beat = (beat_idx == phase_cnt - 20'd1);
    assign run_ok       = F_writedone & B_writedone & (Flen != 6'd0) & (num_OUTCH != 9'd0);
    assign state_dbg    = state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            flen_q      <= 6'd0;
            inch_q      <= 9'd0;
            outch_q     <= 9'd0;
            s_ready_en  <= 1'b0;
            m_valid_en  <= 1'b0;
            m_last      <= 1'b0;
            mac_start   <= 1'b0;
            outch_idx   <= 9'd0;
            beat_idx    <= 20'd0;
            F_writedone <= 1'b0;
            B_writedone <= 1'b0;
            rdy_to_send <= 1'b0;
            conv_done   <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            mac_start <= 1'b0;
            case (state)
                IDLE: begin
                    beat_idx <= 20'd0;
                    if (command == CMD_FEAT) begin
                        flen_q  <= Flen;
                        inch_q  <= num_INCH;
                        outch_q <= num_OUTCH;
                        // An empty load finishes at once; the flag shows next cycle.
                        if (feat_words(Flen, num_INCH) == 20'd0) begin
                            F_writedone <= 1'b1;
                            state       <= HOLD;
                        end else begin
                            s_ready_en <= 1'b1;
                            state      <= FEAT;
                        end
                    end else if (command == CMD_BIAS) begin
                        flen_q  <= Flen;
                        inch_q  <= num_INCH;
                        outch_q <= num_OUTCH;
                        if (ceil4(20'(num_OUTCH)) == 20'd0) begin
                            B_writedone <= 1'b1;
                            state       <= HOLD;
                        end else begin
                            s_ready_en <= 1'b1;
                            state      <= BIAS;
                        end
                    end else if (command == CMD_RUN) begin
                        flen_q    <= Flen;
                        inch_q    <= num_INCH;
                        outch_q   <= num_OUTCH;
                        outch_idx <= 9'd0;
                        if (run_ok) begin
                            s_ready_en <= 1'b1;
                            state      <= WLOAD;
                        end else begin
                            cmd_err   <= 1'b1;
                            conv_done <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                end

                FEAT, BIAS, WLOAD: begin
                    // A zero weight count (num_INCH=0) skips straight to MAC.
                    if ((phase_cnt == 20'd0) || (s_beat && last_in_beat)) begin
                        beat_idx   <= 20'd0;
                        s_ready_en <= 1'b0;
                        if (state == FEAT) begin
                            F_writedone <= 1'b1;
                            state       <= HOLD;
                        end else if (state == BIAS) begin
                            B_writedone <= 1'b1;
                            state       <= HOLD;
                        end else begin
                            mac_start <= 1'b1;
                            state     <= MAC;
                        end
                    end else if (s_beat) begin
                        beat_idx <= beat_idx + 20'd1;
                    end
                end

                MAC: begin
                    if (mac_done) begin
                        beat_idx    <= 20'd0;
                        m_valid_en  <= 1'b1;
                        rdy_to_send <= 1'b1;
                        m_last      <= (ow_cnt == 20'd1);
                        state       <= SEND;
                    end
                end

                SEND: begin
                    if (m_beat) begin
                        if (beat_idx == ow_cnt - 20'd1) begin
                            beat_idx    <= 20'd0;
                            m_valid_en  <= 1'b0;
                            rdy_to_send <= 1'b0;
                            m_last      <= 1'b0;
                            if (outch_idx == outch_q - 9'd1) begin
                                F_writedone <= 1'b0;
                                B_writedone <= 1'b0;
                                conv_done   <= 1'b1;
                                state       <= HOLD;
                            end else begin
                                outch_idx  <= outch_idx + 9'd1;
                                s_ready_en <= 1'b1;
                                state      <= WLOAD;
                            end
                        end else begin
                            beat_idx <= beat_idx + 20'd1;
                            // Registered look-ahead so m_last is high exactly on beat OW-1.
                            m_last   <= (beat_idx + 20'd1 == ow_cnt - 20'd1);
                        end
                    end
                end

                HOLD: begin
                    // Waiting for command 0 keeps a stuck command from re-triggering.
                    if (command == CMD_NOP) begin
                        conv_done <= 1'b0;
                        cmd_err   <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifdef CONV_SEQ_PERF_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_stall_cnt <= 32'd0;
        end else if ((state == IDLE) && (command == CMD_RUN)) begin
            perf_stall_cnt <= 32'd0;
        end else if ((((state == SEND) && !m_beat) || ((state == WLOAD) && !s_beat))
                     && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`else
    assign perf_stall_cnt = 32'd0;
`endif

endmodule
